// File: rtl/jit_pipe_pkg.sv
// Shared constants, result-bus layout and scheduler state type for the JIT
// add/xor pipeline scheduler.
package jit_pipe_pkg;

    localparam int DW       = 16;
    localparam int LAT      = 3;
    localparam int BUS_W    = 25;
    localparam int LO8_LSB  = 0;
    localparam int DATA_LSB = 8;
    localparam int TAG_BIT  = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } sched_state_t;

    // Builds the {tag, data, lo8} result word the datapath carries.
    function automatic logic [BUS_W-1:0] pack_bus(input logic tag, input logic [DW-1:0] data);
        logic [BUS_W-1:0] bus;
        bus = '0;
        bus[TAG_BIT] = tag;
        bus[DATA_LSB +: DW] = data;
        bus[LO8_LSB +: 8] = data[7:0];
        return bus;
    endfunction

endpackage

// File: rtl/jit_pipe_sched_if.sv
// Requester, datapath and response signals of the pipeline scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface jit_pipe_sched_if import jit_pipe_pkg::*; #(parameter int N_REQ = 4);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_sel;
    logic                flush;
    logic                dp_en;
    logic [DW-1:0]       dp_a;
    logic [DW-1:0]       dp_b;
    logic                dp_sel;
    logic                dp_tag;
    logic [DW-1:0]       dp_data;
    logic [7:0]          dp_lo8;
    logic                resp_valid;
    logic                resp_ready;
    logic [IW-1:0]       resp_id;
    logic                resp_tag;
    logic [DW-1:0]       resp_data;
    logic [7:0]          resp_lo8;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, flush,
        input  dp_tag, dp_data, dp_lo8, resp_ready,
        output req_ready, dp_en, dp_a, dp_b, dp_sel,
        output resp_valid, resp_id, resp_tag, resp_data, resp_lo8, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, flush,
        output dp_tag, dp_data, dp_lo8, resp_ready,
        input  req_ready, dp_en, dp_a, dp_b, dp_sel,
        input  resp_valid, resp_id, resp_tag, resp_data, resp_lo8, busy
    );

endinterface

// File: rtl/jit_pipe_sched_arb.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo N. The pointer register belongs to the caller.
module pyc_rr_arb #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            idx = IW'((int'(ptr) + off) % N);
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/jit_pipe_sched.sv
// Round-robin scheduler feeding one shared LAT-stage add/xor datapath and
// returning each result tagged with its requester id via a shadow pipeline.
module jit_pipe_sched import jit_pipe_pkg::*; #(
    parameter int N_REQ = 4
) (
    input logic              sys_clk,
    input logic              sys_rst_n,
    jit_pipe_sched_if.slave  bus
);

    localparam int IW = $clog2(N_REQ);

    logic [LAT-1:0]   vld;
    logic [LAT-1:0]   vld_next;
    logic [IW-1:0]    id_q [LAT];
    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    win;
    logic             any_req;
    logic             stall;
    logic             dp_en;
    logic             grant;
    logic [DW-1:0]    a_arr [N_REQ];
    logic [DW-1:0]    b_arr [N_REQ];
    sched_state_t     state;
    sched_state_t     state_next;

    pyc_rr_arb #(.N(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (win),
        .any_grant (any_req)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*DW +: DW];
        assign b_arr[i] = bus.req_b[i*DW +: DW];
    end

    // A held result at the last stage freezes the shadow and datapath together.
    assign stall = vld[LAT-1] & ~bus.resp_ready;
    assign dp_en = sys_rst_n & ~stall;
    assign grant = dp_en & ~bus.flush & any_req;

    assign bus.dp_en      = dp_en;
    assign bus.req_ready  = grant ? arb_grant : '0;
    assign bus.dp_a       = grant ? a_arr[win] : '0;
    assign bus.dp_b       = grant ? b_arr[win] : '0;
    assign bus.dp_sel     = grant & bus.req_sel[win];
    assign bus.resp_valid = vld[LAT-1];
    assign bus.resp_id    = id_q[LAT-1];
    assign bus.resp_tag   = bus.dp_tag;
    assign bus.resp_data  = bus.dp_data;
    assign bus.resp_lo8   = bus.dp_lo8;
    assign bus.busy       = (state != IDLE);

    always_comb begin
        vld_next = vld;
        if (bus.flush) begin
            vld_next = '0;
        end else if (dp_en) begin
            for (int k = LAT-1; k > 0; k--) begin
                vld_next[k] = vld[k-1];
            end
            vld_next[0] = grant;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld <= '0;
            ptr <= '0;
            for (int k = 0; k < LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld <= vld_next;
            if (dp_en) begin
                id_q[0] <= win;
                for (int k = 1; k < LAT; k++) begin
                    id_q[k] <= id_q[k-1];
                end
            end
            if (grant) begin
                ptr <= IW'((int'(win) + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving RUN/STALL looks at the next valid bits so busy drops with the last entry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = RUN;
            RUN:     if (vld_next == '0) state_next = IDLE;
                     else if (stall) state_next = STALL;
            STALL:   if (vld_next == '0) state_next = IDLE;
                     else if (bus.resp_ready) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jit_pipe_sched.sv
// Scoreboard bench for jit_pipe_sched: an external gated datapath, directed
// scenarios, then random traffic checked against a queue-based reference.
module tb_jit_pipe_sched;
    import jit_pipe_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          tag;
        int            age;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic [BUS_W-1:0] stage [LAT];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rr_ptr = 0;

    jit_pipe_sched_if #(.N_REQ(N)) bus();

    jit_pipe_sched #(.N_REQ(N)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // External datapath: LAT result registers sharing dp_en.
    always @(posedge sys_clk) begin
        if (bus.dp_en) begin
            stage[0] <= pack_bus(bus.dp_a == bus.dp_b, bus.dp_sel ? bus.dp_a + bus.dp_b : bus.dp_a ^ bus.dp_b);
            for (int k = LAT-1; k > 0; k--) stage[k] <= stage[k-1];
        end
    end
    assign bus.dp_tag  = stage[LAT-1][TAG_BIT];
    assign bus.dp_data = stage[LAT-1][DATA_LSB +: DW];
    assign bus.dp_lo8  = stage[LAT-1][LO8_LSB +: 8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                                 input logic [N-1:0] sel, input logic fl, input logic rdy);
        bus.req_valid  = v;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_sel    = sel;
        bus.flush      = fl;
        bus.resp_ready = rdy;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus('0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    function automatic logic [N*DW-1:0] rand_ops();
        return {$urandom, $urandom};
    endfunction

    // Response monitor: a presented result must match the oldest outstanding request.
    always @(negedge sys_clk) begin : monitor
        logic exp_rv;
        if (!sys_rst_n) begin
            checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        end else begin
            exp_rv = (sb.size() > 0) && (sb[0].age == LAT);
            checkOutput("busy", 32'(bus.busy), 32'(sb.size() > 0));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            if (bus.resp_valid && sb.size() > 0) begin
                checkOutput("resp_id", 32'(bus.resp_id), 32'(sb[0].id));
                checkOutput("resp_data", 32'(bus.resp_data), 32'(sb[0].data));
                checkOutput("resp_lo8", 32'(bus.resp_lo8), 32'(sb[0].data[7:0]));
                checkOutput("resp_tag", 32'(bus.resp_tag), 32'(sb[0].tag));
                if (bus.resp_ready) void'(sb.pop_front());
            end
        end
    end

    // Issue tracker: predicts grants and enable, and queues expected results.
    always @(negedge sys_clk) begin : issue
        logic [N-1:0]  exp_ready;
        logic          exp_en;
        logic [DW-1:0] a, b;
        logic          s;
        int            win;
        exp_t          e;
        #1;
        if (!sys_rst_n) begin
            checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("rst_dp_en", 32'(bus.dp_en), 32'd0);
            sb.delete();
            rr_ptr = 0;
        end else begin
            exp_en = !((sb.size() > 0) && (sb[0].age == LAT) && !bus.resp_ready);
            win = -1;
            if (exp_en && !bus.flush) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && bus.req_valid[(rr_ptr + k) % N]) win = (rr_ptr + k) % N;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            checkOutput("dp_en", 32'(bus.dp_en), 32'(exp_en));
            checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            if (bus.flush) begin
                sb.delete();
            end else if (exp_en) begin
                foreach (sb[i]) sb[i].age = sb[i].age + 1;
                if (win >= 0) begin
                    a = bus.req_a[win*DW +: DW];
                    b = bus.req_b[win*DW +: DW];
                    s = bus.req_sel[win];
                    e.id   = IW'(win);
                    e.data = s ? a + b : a ^ b;
                    e.tag  = (a == b);
                    e.age  = 1;
                    sb.push_back(e);
                    rr_ptr = (win + 1) % N;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic [N*DW-1:0] a, b;
        logic seen;
        int held;
        bus.req_valid = '1; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0;
        bus.flush = 1'b0; bus.resp_ready = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        $display("[TB] reset released, first grant expected for requester 0");
        applyStimulus('1, rand_ops(), rand_ops(), 4'hF, 1'b0, 1'b1);
        idle(LAT + 2);

        a = '0; b = '0;
        a[1*DW +: DW] = 16'd3; b[1*DW +: DW] = 16'd5;
        applyStimulus(4'b0010, a, b, 4'b0010, 1'b0, 1'b1);
        idle(LAT + 2);

        a = '0; b = '0;
        a[2*DW +: DW] = 16'h00FF; b[2*DW +: DW] = 16'h00FF;
        applyStimulus(4'b0100, a, b, 4'b0000, 1'b0, 1'b1);
        idle(LAT + 2);

        repeat (12) applyStimulus('1, rand_ops(), rand_ops(), 4'($urandom), 1'b0, 1'b1);
        idle(LAT + 2);

        // Backpressure: hold the first response for five cycles while requests keep arriving.
        seen = 1'b0;
        held = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            logic rdy;
            if (bus.resp_valid) seen = 1'b1;
            rdy = !(seen && held < 5);
            if (!rdy) held++;
            applyStimulus((cyc < 4 || !rdy) ? 4'hF : 4'h0, rand_ops(), rand_ops(), 4'($urandom), 1'b0, rdy);
        end
        checkOutput("bp_first_resp_seen", 32'(seen), 32'd1);
        checkOutput("bp_drained", 32'(sb.size()), 32'd0);

        applyStimulus(4'b0001, rand_ops(), rand_ops(), 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b0010, rand_ops(), rand_ops(), 4'h0, 1'b0, 1'b1);
        applyStimulus(4'b0000, '0, '0, '0, 1'b1, 1'b1);
        idle(LAT + 2);

        applyStimulus(4'b0100, rand_ops(), rand_ops(), 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b1000, rand_ops(), rand_ops(), 4'h0, 1'b0, 1'b1);
        bus.req_valid = '0;
        #2;
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        idle(LAT + 2);

        $display("[TB] random traffic phase");
        repeat (400) begin
            applyStimulus(4'($urandom), rand_ops(), rand_ops(), 4'($urandom),
                          ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(LAT + 4);
        checkOutput("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
